// File: rtl/inst_rom_arbiter.sv
// Two-requester round-robin arbiter in front of a single instruction-ROM port.
// Flags misaligned requests and ROM timeouts; all outputs are registered.
module inst_rom_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_request_i,
  input  logic [ADDR_WIDTH-1:0] m0_instAddr_i,
  output logic [DATA_WIDTH-1:0] m0_inst_o,
  output logic                  m0_dataOk_o,
  output logic                  m0_error_o,
  input  logic                  m1_request_i,
  input  logic [ADDR_WIDTH-1:0] m1_instAddr_i,
  output logic [DATA_WIDTH-1:0] m1_inst_o,
  output logic                  m1_dataOk_o,
  output logic                  m1_error_o,
  output logic                  rom_request_o,
  output logic [ADDR_WIDTH-1:0] rom_instAddr_o,
  input  logic [DATA_WIDTH-1:0] rom_inst_i,
  input  logic                  rom_dataOk_i,
  output logic                  busy_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rom_req_q, rom_req_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH-1:0] m0_inst_q, m0_inst_d, m1_inst_q, m1_inst_d;
  logic                  m0_ok_q, m0_ok_d, m1_ok_q, m1_ok_d;
  logic                  m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic                  busy_q, busy_d;

  logic                  grant;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic                  done, done_err, done_owner;
  logic [DATA_WIDTH-1:0] done_data;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rom_req_d    = rom_req_q;
    rom_addr_d   = rom_addr_q;
    m0_inst_d    = m0_inst_q;
    m1_inst_d    = m1_inst_q;
    m0_ok_d      = 1'b0;
    m1_ok_d      = 1'b0;
    m0_err_d     = 1'b0;
    m1_err_d     = 1'b0;
    grant        = 1'b0;
    grant_addr   = '0;
    done         = 1'b0;
    done_err     = 1'b0;
    done_owner   = owner_q;
    done_data    = '0;

    case (state_q)
      S_IDLE: begin
        if (m0_request_i || m1_request_i) begin
          grant        = (m0_request_i && m1_request_i) ? ~last_grant_q : m1_request_i;
          grant_addr   = grant ? m1_instAddr_i : m0_instAddr_i;
          owner_d      = grant;
          last_grant_d = grant;
          if (grant_addr[1:0] != 2'b00) begin
            state_d    = S_RESP;
            done       = 1'b1;
            done_err   = 1'b1;
            done_owner = grant;
          end else begin
            rom_req_d  = 1'b1;
            rom_addr_d = grant_addr;
            cnt_d      = '0;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (rom_dataOk_i) begin
          rom_req_d = 1'b0;
          state_d   = S_RESP;
          done      = 1'b1;
          done_data = rom_inst_i;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rom_req_d = 1'b0;
          state_d   = S_RESP;
          done      = 1'b1;
          done_err  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Completion flags are loaded on entry to RESP so the pulse coincides with that state.
    if (done) begin
      if (done_owner) begin
        m1_ok_d   = 1'b1;
        m1_err_d  = done_err;
        m1_inst_d = done_data;
      end else begin
        m0_ok_d   = 1'b1;
        m0_err_d  = done_err;
        m0_inst_d = done_data;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      rom_req_q    <= 1'b0;
      rom_addr_q   <= '0;
      m0_inst_q    <= '0;
      m1_inst_q    <= '0;
      m0_ok_q      <= 1'b0;
      m1_ok_q      <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rom_req_q    <= rom_req_d;
      rom_addr_q   <= rom_addr_d;
      m0_inst_q    <= m0_inst_d;
      m1_inst_q    <= m1_inst_d;
      m0_ok_q      <= m0_ok_d;
      m1_ok_q      <= m1_ok_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
      busy_q       <= busy_d;
    end
  end

  assign m0_inst_o      = m0_inst_q;
  assign m0_dataOk_o    = m0_ok_q;
  assign m0_error_o     = m0_err_q;
  assign m1_inst_o      = m1_inst_q;
  assign m1_dataOk_o    = m1_ok_q;
  assign m1_error_o     = m1_err_q;
  assign rom_request_o  = rom_req_q;
  assign rom_instAddr_o = rom_addr_q;
  assign busy_o         = busy_q;

endmodule
